// File: rtl/lab4_net_bus_credit_sched_if.sv
// ---------------------------------------------------------------------------
// Module : lab4_net_bus_credit_sched_if
// Brief  : Queue/bus/credit signal bundle between input queues, scheduler
//          and outports of the lab4_net bus network.
// Rev    : 1.0  initial release
// ---------------------------------------------------------------------------
`default_nettype none

interface lab4_net_bus_credit_sched_if;
  logic [3:0]      inq_val;
  logic [3:0][1:0] inq_dest;
  logic [3:0]      inq_rdy;
  logic [1:0]      bus_sel;
  logic            bus_en;
  logic [3:0]      out_val;
  logic [3:0]      credit_ret;
  logic            credit_err;

  modport master (
    output inq_val, inq_dest, credit_ret,
    input  inq_rdy, bus_sel, bus_en, out_val, credit_err
  );

  modport slave (
    input  inq_val, inq_dest, credit_ret,
    output inq_rdy, bus_sel, bus_en, out_val, credit_err
  );
endinterface

`default_nettype wire

// File: rtl/lab4_net_bus_credit_sched.sv
// ---------------------------------------------------------------------------
// Module : lab4_net_bus_credit_sched
// Brief  : Round-robin bus arbiter with per-outport credit counters; grants
//          never look at downstream ready, only at locally held credits.
// Rev    : 1.0  initial release
// ---------------------------------------------------------------------------
`default_nettype none

module lab4_net_bus_credit_sched #(
  parameter int C_NPORTS  = 4,
  parameter int C_CREDITS = 2
) (
  input logic                           clk,
  input logic                           rst_n,
  lab4_net_bus_credit_sched_if.slave    bus
);

  localparam logic [2:0] C_CRED_MAX = 3'(C_CREDITS);

  logic [3:0][2:0] credit_q, credit_d;
  logic [1:0]      ptr_q, ptr_d;
  logic [3:0]      out_val_q, out_val_d;
  logic            err_q, err_d;

  logic [3:0]      elig;
  logic            grant;
  logic [1:0]      gsel;
  logic [1:0]      gdest;
  logic [3:0]      ovf;

  always_comb begin
    elig = '0;
    for (int i = 0; i < C_NPORTS; i++) begin
      elig[i] = bus.inq_val[i] && (credit_q[bus.inq_dest[i]] != 3'd0);
    end
  end

  // Scan from lowest priority upward so the entry nearest ptr wins last.
  always_comb begin
    grant = 1'b0;
    gsel  = 2'd0;
    for (int k = C_NPORTS - 1; k >= 0; k--) begin
      if (elig[ptr_q + 2'(k)]) begin
        grant = 1'b1;
        gsel  = ptr_q + 2'(k);
      end
    end
  end

  assign gdest = bus.inq_dest[gsel];

  assign bus.inq_rdy    = (grant && rst_n) ? (4'b0001 << gsel) : 4'b0000;
  assign bus.bus_en     = grant && rst_n;
  assign bus.bus_sel    = grant ? gsel : 2'd0;
  assign bus.out_val    = out_val_q;
  assign bus.credit_err = err_q;

  for (genvar p = 0; p < C_NPORTS; p++) begin : g_credit
    logic dec, inc;
    assign dec = grant && (gdest == 2'(p));
    assign inc = bus.credit_ret[p];
    // A return on a full counter with no offsetting grant is an overflow.
    assign ovf[p] = inc && !dec && (credit_q[p] == C_CRED_MAX);
    assign credit_d[p] = (dec && !inc)           ? credit_q[p] - 3'd1 :
                         (inc && !dec && !ovf[p]) ? credit_q[p] + 3'd1 :
                                                    credit_q[p];
  end

  assign ptr_d     = grant ? gsel + 2'd1 : ptr_q;
  assign out_val_d = grant ? (4'b0001 << gdest) : 4'b0000;
  assign err_d     = err_q | (|ovf);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      credit_q  <= {4{C_CRED_MAX}};
      ptr_q     <= 2'd0;
      out_val_q <= 4'b0000;
      err_q     <= 1'b0;
    end else begin
      credit_q  <= credit_d;
      ptr_q     <= ptr_d;
      out_val_q <= out_val_d;
      err_q     <= err_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_lab4_net_bus_credit_sched.sv
// ---------------------------------------------------------------------------
// Module : tb_lab4_net_bus_credit_sched
// Brief  : Directed bench; expected out_val queued at grant time, checked
//          one cycle later.
// Rev    : 1.0  initial release
// ---------------------------------------------------------------------------
`default_nettype none

module tb_lab4_net_bus_credit_sched;
  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  logic [3:0]      val_r;
  logic [3:0][1:0] dest_r;
  logic [3:0]      ret_r;
  logic [3:0]      sb[$];

  lab4_net_bus_credit_sched_if ifc();

  assign ifc.inq_val    = val_r;
  assign ifc.inq_dest   = dest_r;
  assign ifc.credit_ret = ret_r;

  lab4_net_bus_credit_sched #(.C_NPORTS(4), .C_CREDITS(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [3:0] v, input logic [7:0] d, input logic [3:0] r);
    val_r  = v;
    dest_r = d;
    ret_r  = r;
  endtask

  task automatic check_now(input logic [3:0] er, input logic [1:0] es, input logic ee);
    logic [3:0] eov;
    @(negedge clk);
    eov = (sb.size() != 0) ? sb.pop_front() : 4'hx;
    chk("out_val", {4'b0, ifc.out_val}, {4'b0, eov});
    chk("inq_rdy", {4'b0, ifc.inq_rdy}, {4'b0, er});
    chk("bus_sel", {6'b0, ifc.bus_sel}, {6'b0, es});
    chk("bus_en",  {7'b0, ifc.bus_en},  {7'b0, ee});
    sb.push_back(ee ? (4'b0001 << dest_r[es]) : 4'b0000);
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc(input logic [3:0] er, input logic [1:0] es, input logic ee);
    check_now(er, es, ee);
    adv();
  endtask

  initial begin
    logic [1:0] g;
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    drive(4'b1111, 8'h00, 4'b0000);

    // reset holds grants off even with every queue valid
    @(negedge clk);
    chk("rst_rdy", {4'b0, ifc.inq_rdy}, 8'h00);
    chk("rst_en",  {7'b0, ifc.bus_en},  8'h00);
    chk("rst_ov",  {4'b0, ifc.out_val}, 8'h00);
    chk("rst_err", {7'b0, ifc.credit_err}, 8'h00);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    sb.push_back(4'b0000);

    // single grant, inport 0 -> outport 2
    drive(4'b0001, {2'd0, 2'd0, 2'd0, 2'd2}, 4'b0000);
    cyc(4'b0001, 2'd0, 1'b1);
    drive(4'b0000, 8'h00, 4'b0100);
    cyc(4'b0000, 2'd0, 1'b0);

    // round robin, ptr starts at 1; credits returned with out_val
    for (int k = 0; k < 8; k++) begin
      g = 2'((k + 1) % 4);
      drive(4'b1111, {2'd3, 2'd2, 2'd1, 2'd0},
            (k == 0) ? 4'b0000 : (4'b0001 << (k % 4)));
      cyc(4'b0001 << g, g, 1'b1);
    end
    drive(4'b0000, 8'h00, 4'b0001);
    cyc(4'b0000, 2'd0, 1'b0);
    chk("rr_err", {7'b0, ifc.credit_err}, 8'h00);

    // credit exhaustion: inport 1 -> outport 3
    drive(4'b0010, {2'd0, 2'd0, 2'd3, 2'd0}, 4'b0000);
    cyc(4'b0010, 2'd1, 1'b1);
    cyc(4'b0010, 2'd1, 1'b1);
    cyc(4'b0000, 2'd0, 1'b0);
    cyc(4'b0000, 2'd0, 1'b0);
    ret_r = 4'b1000;
    cyc(4'b0000, 2'd0, 1'b0);
    ret_r = 4'b0000;
    cyc(4'b0010, 2'd1, 1'b1);
    cyc(4'b0000, 2'd0, 1'b0);
    drive(4'b0000, 8'h00, 4'b1000);
    cyc(4'b0000, 2'd0, 1'b0);
    cyc(4'b0000, 2'd0, 1'b0);

    // drain outport 0 credits (ptr=2, inport 0 found by wrap)
    drive(4'b0001, 8'h00, 4'b0000);
    cyc(4'b0001, 2'd0, 1'b1);
    cyc(4'b0001, 2'd0, 1'b1);

    // no head-of-line blocking: inport 2 -> outport 1 flows past inport 0
    drive(4'b0101, {2'd0, 2'd1, 2'd0, 2'd0}, 4'b0000);
    cyc(4'b0100, 2'd2, 1'b1);
    ret_r = 4'b0010;
    for (int k = 0; k < 3; k++) cyc(4'b0100, 2'd2, 1'b1);
    drive(4'b0000, 8'h00, 4'b0010);
    cyc(4'b0000, 2'd0, 1'b0);
    ret_r = 4'b0001;
    cyc(4'b0000, 2'd0, 1'b0);
    cyc(4'b0000, 2'd0, 1'b0);
    ret_r = 4'b0000;
    cyc(4'b0000, 2'd0, 1'b0);

    // same-cycle grant and return on outport 2, then overflow
    drive(4'b1000, {2'd2, 2'd0, 2'd0, 2'd0}, 4'b0100);
    cyc(4'b1000, 2'd3, 1'b1);
    chk("sim_err", {7'b0, ifc.credit_err}, 8'h00);
    drive(4'b0000, 8'h00, 4'b0100);
    cyc(4'b0000, 2'd0, 1'b0);
    chk("ovf_err", {7'b0, ifc.credit_err}, 8'h01);
    ret_r = 4'b0000;
    cyc(4'b0000, 2'd0, 1'b0);
    cyc(4'b0000, 2'd0, 1'b0);
    chk("err_sticky", {7'b0, ifc.credit_err}, 8'h01);

    // mid-operation reset: move ptr to 2 and take one credit from outport 1
    drive(4'b0010, {2'd0, 2'd0, 2'd1, 2'd0}, 4'b0000);
    cyc(4'b0010, 2'd1, 1'b1);
    drive(4'b0101, {2'd0, 2'd2, 2'd1, 2'd0}, 4'b0000);
    check_now(4'b0100, 2'd2, 1'b1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_rdy", {4'b0, ifc.inq_rdy}, 8'h00);
    chk("mid_rst_en",  {7'b0, ifc.bus_en},  8'h00);
    chk("mid_rst_ov",  {4'b0, ifc.out_val}, 8'h00);
    sb.delete();
    adv();
    rst_n = 1'b1;
    sb.push_back(4'b0000);
    chk("post_rst_err", {7'b0, ifc.credit_err}, 8'h00);
    cyc(4'b0001, 2'd0, 1'b1);
    drive(4'b0010, {2'd0, 2'd0, 2'd1, 2'd0}, 4'b0000);
    cyc(4'b0010, 2'd1, 1'b1);
    cyc(4'b0010, 2'd1, 1'b1);
    cyc(4'b0000, 2'd0, 1'b0);
    drive(4'b0000, 8'h00, 4'b0000);
    cyc(4'b0000, 2'd0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

`default_nettype wire
